math_reduce_pipe: RTL and testbench
===================================

// Module: math_reduce_pipe
// PURPOSE
//  Pipelined N-lane reduction unit with an op selected per beat and valid/ready flow control.
//  Reduces I_COUNT lanes of I_WIDTH to one O_WIDTH result through a binary tree, registered every PIPE_EVERY levels.
//  Successor to the fixed-op math unit; use it wherever a reduction result must tolerate downstream backpressure.
// PARAMETERS
//  I_COUNT    5  input lane count, >=1
//  I_WIDTH    8  lane width, >=1
//  O_WIDTH   16  result width, >=I_WIDTH
//  PIPE_EVERY 1  tree levels per register stage, >=1
// PORTS
//  clk_i        in   1                  clock, all logic on rising edge
//  rst_i        in   1                  synchronous reset, active-high
//  in_data_i    in   I_COUNT*I_WIDTH    packed lanes; lane k = [k*I_WIDTH +: I_WIDTH]
//  in_op_i      in   3                  op code, travels with the beat
//  in_valid_i   in   1                  input beat valid
//  in_ready_o   out  1                  input beat accepted when valid&ready
//  out_data_o   out  O_WIDTH            reduction result
//  out_ovf_o    out  1                  ADD result truncated (full sum >= 2**O_WIDTH)
//  out_valid_o  out  1                  result valid
//  out_ready_i  in   1                  downstream ready
// BEHAVIOUR
//  Ops: 0 OR, 1 AND, 2 XOR, 3 ADD, 4 UMAX, 5 UMIN, 6 SMAX, 7 SMIN (signed ops use two's complement lanes).
//  Tree depth LEVELS = max(1, $clog2(I_COUNT)); register stages S = ceil(LEVELS/PIPE_EVERY).
//  The final stage is always registered.
//  Latency: exactly S cycles from acceptance to out_valid_o when never stalled.
//  Missing leaves to the next power of two are padded with the op identity:
//  OR/XOR/ADD/UMAX pad with 0; AND/UMIN with all-ones; SMAX with most-negative; SMIN with most-positive.
//  Width rules:
//   Bitwise and unsigned MAX/MIN results are zero-extended to O_WIDTH; signed MAX/MIN are sign-extended.
//   ADD sums lanes unsigned at I_WIDTH+$clog2(I_COUNT)+1 bits; out_data_o = sum mod 2**O_WIDTH.
//   out_ovf_o=1 iff any truncated bit is set; out_ovf_o=0 for all non-ADD ops.
//  Flow control: global stage enable en = out_ready_i | ~out_valid_o.
//   in_ready_o = en (combinational, no dependence on in_valid_i).
//   When en=1 every stage advances; stage valid bits carry bubbles (bubbles are not collapsed).
//   When en=0 all stage registers, out_data_o, out_ovf_o and out_valid_o hold; held output is stable until taken.
//   A simultaneous output take and input accept in one cycle sustains 1 beat/cycle throughput.
//  Op code is pipelined alongside the partial results; mixed ops in flight are fully independent.
//  Reset: all stage valid bits, out_valid_o and out_ovf_o go to 0, and out_data_o to 0, at the first edge with rst_i=1.
//   in_ready_o=1 during reset; beats presented under reset are discarded.
//   Reset mid-stream flushes all in-flight beats; no output appears for them.
//  Data registers need no reset except the output stage (0) to keep out_data_o defined.
//  Undefined op codes cannot occur (3-bit fully decoded).
// TESTING
//  1 I_COUNT=5,I_WIDTH=8,PIPE_EVERY=1 (S=3): OR of {01,02,04,08,10} -> 1F exactly 3 cycles after accept, ovf=0.
//  2 Identity padding:
//    a. AND of five FF -> 00FF.
//    b. UMIN of {09,03,07,05,04} -> 0003.
//    c. SMIN of {7F,80,00,01,FF} -> FF80.
//    d. SMAX of same -> 007F.
//  3 ADD overflow, O_WIDTH=8: five lanes of FF -> out_data=FB, out_ovf=1; O_WIDTH=16 -> 04FB, ovf=0.
//  4 Backpressure:
//    a. Stream 20 random beats of random ops.
//    b. Hold out_ready_i=0 for 7 cycles mid-stream -> in_ready_o=0 throughout and no beat lost, duplicated or reordered.
//    c. Every result matches the golden model; output stable while stalled.
//  5 Throughput: out_ready_i=1 and in_valid_i=1 for 512 cycles -> 512 results, one per cycle after a 3-cycle fill.
//  6 Reset mid-operation:
//    a. rst_i=1 for 1 cycle with 3 beats in flight -> out_valid_o=0 next cycle, none of the 3 emerge.
//    b. The first beat after reset is returned correctly after S cycles.
//    c. Repeat with PIPE_EVERY=2 (S=2) and I_COUNT=1 (S=1, result = lane 0 extended).

Source files
------------

// File: rtl/math_reduce_pipe.sv
// Pipelined I_COUNT-lane reduction (OR/AND/XOR/ADD/UMAX/UMIN/SMAX/SMIN) with the op carried per beat.
// Latency: ceil(LEVELS/PIPE_EVERY) cycles from accept to out_valid_o; the final stage is always registered.
// Backpressure: one global enable (out_ready_i | ~out_valid_o) freezes every stage; in_ready_o equals it.
module math_reduce_pipe #(
  parameter int I_COUNT    = 5,
  parameter int I_WIDTH    = 8,
  parameter int O_WIDTH    = 16,
  parameter int PIPE_EVERY = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [I_COUNT*I_WIDTH-1:0] in_data_i,
  input  logic [2:0]                 in_op_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [O_WIDTH-1:0]         out_data_o,
  output logic                       out_ovf_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int LEVELS = (I_COUNT > 1) ? $clog2(I_COUNT) : 1;
  localparam int LEAVES = 1 << LEVELS;
  // Node width is wide enough that the full ADD never wraps inside the tree.
  localparam int W      = I_WIDTH + $clog2(I_COUNT) + 1;
  localparam int XW     = (W > O_WIDTH) ? W : O_WIDTH + 1;
  localparam logic [I_WIDTH-1:0] LANE_MSB = I_WIDTH'(1) << (I_WIDTH - 1);

  // Signed ops carry sign-extended lanes so the wide compare is a true signed compare.
  function automatic logic [W-1:0] f_ext(input logic [2:0] op, input logic [I_WIDTH-1:0] x);
    if (op == 3'd6 || op == 3'd7) return W'($signed(x));
    return W'(x);
  endfunction

  // Identity element used for leaves beyond I_COUNT.
  function automatic logic [W-1:0] f_ident(input logic [2:0] op);
    case (op)
      3'd1, 3'd5: return W'({I_WIDTH{1'b1}});
      3'd6:       return f_ext(op, LANE_MSB);
      3'd7:       return f_ext(op, ~LANE_MSB);
      default:    return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] f_comb(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a | b;
      3'd1:    return a & b;
      3'd2:    return a ^ b;
      3'd3:    return a + b;
      3'd4:    return (a > b) ? a : b;
      3'd5:    return (a < b) ? a : b;
      3'd6:    return ($signed(a) > $signed(b)) ? a : b;
      default: return ($signed(a) < $signed(b)) ? a : b;
    endcase
  endfunction

  logic               en;
  logic [O_WIDTH-1:0] out_data_d, out_data_q;
  logic               out_ovf_d, out_ovf_q;
  logic               out_valid_d, out_valid_q;
  logic [W-1:0]       root;
  logic [XW-1:0]      sum_x;

  assign en          = out_ready_i | ~out_valid_q;
  assign in_ready_o  = en;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_valid_o = out_valid_q;

  // Level 0 is the padded leaf row; levels 1..LEVELS-1 are tree rows, registered every PIPE_EVERY.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NODES = LEAVES >> l;
    logic [W-1:0] val [NODES];
    logic [2:0]   op;
    logic         vld;

    if (l == 0) begin : g_leaf
      assign op  = in_op_i;
      assign vld = in_valid_i;
      for (genvar k = 0; k < NODES; k++) begin : g_lane
        if (k < I_COUNT) begin : g_real
          assign val[k] = f_ext(in_op_i, in_data_i[k*I_WIDTH +: I_WIDTH]);
        end else begin : g_pad
          assign val[k] = f_ident(in_op_i);
        end
      end
    end else begin : g_node
      logic [W-1:0] val_d [NODES];
      logic [2:0]   op_d;
      logic         vld_d;

      // Pairwise combine of the previous row; the op code rides along unchanged.
      always_comb begin
        op_d  = g_lvl[l-1].op;
        vld_d = g_lvl[l-1].vld;
        for (int i = 0; i < NODES; i++) begin
          val_d[i] = f_comb(g_lvl[l-1].op, g_lvl[l-1].val[2*i], g_lvl[l-1].val[2*i+1]);
        end
      end

      if ((l % PIPE_EVERY) == 0) begin : g_reg
        logic [W-1:0] val_q [NODES];
        logic [2:0]   op_q;
        logic         vld_q;

        // Stage register: only the valid bit is reset, data just follows the enable.
        always_ff @(posedge clk_i) begin
          if (rst_i)   vld_q <= 1'b0;
          else if (en) vld_q <= vld_d;
          if (en) begin
            val_q <= val_d;
            op_q  <= op_d;
          end
        end
        assign val = val_q;
        assign op  = op_q;
        assign vld = vld_q;
      end else begin : g_wire
        assign val = val_d;
        assign op  = op_d;
        assign vld = vld_d;
      end
    end
  end

  // Root combine plus result formatting (extension, ADD truncation and overflow).
  always_comb begin
    root        = f_comb(g_lvl[LEVELS-1].op, g_lvl[LEVELS-1].val[0], g_lvl[LEVELS-1].val[1]);
    sum_x       = XW'(root);
    out_data_d  = O_WIDTH'(root[I_WIDTH-1:0]);
    out_ovf_d   = 1'b0;
    out_valid_d = g_lvl[LEVELS-1].vld;
    case (g_lvl[LEVELS-1].op)
      3'd3: begin
        out_data_d = sum_x[O_WIDTH-1:0];
        out_ovf_d  = |sum_x[XW-1:O_WIDTH];
      end
      3'd6, 3'd7: out_data_d = O_WIDTH'($signed(root[I_WIDTH-1:0]));
      default: ;
    endcase
  end

  // Output stage: fully reset so out_data_o is defined, held while downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_math_reduce_pipe.sv
// Scoreboard bench for math_reduce_pipe over four parameter sets sharing one stimulus stream.
// Instances: 0 = (5,8,16,1) S=3, 1 = O_WIDTH 8 S=3, 2 = PIPE_EVERY 2 S=2, 3 = I_COUNT 1 S=1.
// Each instance has its own expected-result queue, filled on accept and drained on take.
module tb_math_reduce_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] in_data;
  logic [2:0]  in_op;
  logic        in_valid;
  logic        out_ready;

  logic        ir [4];
  logic        ov [4];
  logic        of [4];
  logic [15:0] od0, od2, od3;
  logic [7:0]  od1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] q [4][$];
  logic        stall [4];
  logic [16:0] held [4];
  int          takes [4];
  int          lat [4];
  logic        dir_vld;
  logic [16:0] dir_e16, dir_e8;

  always #5 clk = ~clk;

  math_reduce_pipe #(.I_COUNT(5), .I_WIDTH(8), .O_WIDTH(16), .PIPE_EVERY(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_op_i(in_op), .in_valid_i(in_valid),
    .in_ready_o(ir[0]), .out_data_o(od0), .out_ovf_o(of[0]), .out_valid_o(ov[0]),
    .out_ready_i(out_ready));
  math_reduce_pipe #(.I_COUNT(5), .I_WIDTH(8), .O_WIDTH(8), .PIPE_EVERY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_op_i(in_op), .in_valid_i(in_valid),
    .in_ready_o(ir[1]), .out_data_o(od1), .out_ovf_o(of[1]), .out_valid_o(ov[1]),
    .out_ready_i(out_ready));
  math_reduce_pipe #(.I_COUNT(5), .I_WIDTH(8), .O_WIDTH(16), .PIPE_EVERY(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_op_i(in_op), .in_valid_i(in_valid),
    .in_ready_o(ir[2]), .out_data_o(od2), .out_ovf_o(of[2]), .out_valid_o(ov[2]),
    .out_ready_i(out_ready));
  math_reduce_pipe #(.I_COUNT(1), .I_WIDTH(8), .O_WIDTH(16), .PIPE_EVERY(1)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data[7:0]), .in_op_i(in_op), .in_valid_i(in_valid),
    .in_ready_o(ir[3]), .out_data_o(od3), .out_ovf_o(of[3]), .out_valid_o(ov[3]),
    .out_ready_i(out_ready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Golden model straight from the op definitions: reduce only the real lanes.
  function automatic logic [16:0] golden(input logic [2:0] op, input logic [39:0] d,
                                         input int n, input int ow);
    int acc, v, sv, mask;
    logic ovf;
    acc  = 0;
    mask = (1 << ow) - 1;
    for (int k = 0; k < n; k++) begin
      v  = int'(d[k*8 +: 8]);
      sv = int'($signed(d[k*8 +: 8]));
      if (k == 0) acc = (op >= 3'd6) ? sv : v;
      else begin
        case (op)
          3'd0: acc = acc | v;
          3'd1: acc = acc & v;
          3'd2: acc = acc ^ v;
          3'd3: acc = acc + v;
          3'd4: acc = (v > acc) ? v : acc;
          3'd5: acc = (v < acc) ? v : acc;
          3'd6: acc = (sv > acc) ? sv : acc;
          default: acc = (sv < acc) ? sv : acc;
        endcase
      end
    end
    ovf = (op == 3'd3) && (acc > mask);
    return {ovf, 16'(acc & mask)};
  endfunction

  task automatic mon(input int idx, input logic irdy, input logic ovld,
                     input logic [15:0] od, input logic oovf);
    logic [16:0] e;
    if (rst) begin
      q[idx].delete();
      stall[idx] = 1'b0;
      return;
    end
    if (stall[idx])
      check($sformatf("hold%0d", idx), {15'd0, ovld, oovf, od}, {15'd0, 1'b1, held[idx]});
    if (ovld && out_ready) begin
      if (q[idx].size() == 0) check($sformatf("spurious%0d", idx), 32'd1, 32'd0);
      else begin
        e = q[idx].pop_front();
        check($sformatf("dat%0d", idx), {16'd0, od}, {16'd0, e[15:0]});
        check($sformatf("ovf%0d", idx), {31'd0, oovf}, {31'd0, e[16]});
      end
      takes[idx]++;
    end
    stall[idx] = ovld && !out_ready;
    held[idx]  = {oovf, od};
    if (in_valid && irdy) begin
      if (dir_vld && idx < 2) q[idx].push_back((idx == 0) ? dir_e16 : dir_e8);
      else q[idx].push_back(golden(in_op, in_data, (idx == 3) ? 1 : 5, (idx == 1) ? 8 : 16));
    end
  endtask

  // Inputs are stable and outputs settled at the falling edge; the next rising edge commits.
  always @(negedge clk) begin
    mon(0, ir[0], ov[0], od0, of[0]);
    mon(1, ir[1], ov[1], {8'd0, od1}, of[1]);
    mon(2, ir[2], ov[2], od2, of[2]);
    mon(3, ir[3], ov[3], od3, of[3]);
  end

  task automatic send(input logic [2:0] op, input logic [39:0] d, input logic dv,
                      input logic [16:0] e16, input logic [16:0] e8);
    @(posedge clk); #1;
    in_op = op; in_data = d; in_valid = 1'b1;
    dir_vld = dv; dir_e16 = e16; dir_e8 = e8;
  endtask

  task automatic send_rand();
    logic [63:0] r;
    r = {$urandom, $urandom};
    send(3'($urandom_range(0, 7)), r[39:0], 1'b0, 17'd0, 17'd0);
  endtask

  task automatic drain();
    int left;
    @(posedge clk); #1;
    in_valid = 1'b0; dir_vld = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      left = q[0].size() + q[1].size() + q[2].size() + q[3].size();
      if (left == 0) break;
    end
    check("drain", left, 0);
  endtask

  task automatic lat_probe(input logic [2:0] op, input logic [39:0] d, input logic dv,
                           input logic [16:0] e16, input logic [16:0] e8);
    for (int i = 0; i < 4; i++) lat[i] = 0;
    out_ready = 1'b1;
    send(op, d, dv, e16, e8);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin in_valid = 1'b0; dir_vld = 1'b0; end
      for (int i = 0; i < 4; i++) if (lat[i] == 0 && ov[i]) lat[i] = k;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("lat%0d", i), lat[i], (i == 3) ? 1 : (i == 2) ? 2 : 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, t0, acc;
    for (int i = 0; i < 4; i++) begin stall[i] = 1'b0; takes[i] = 0; end
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_data = '0; out_ready = 1'b1;
    dir_vld = 1'b0; dir_e16 = '0; dir_e8 = '0;

    // Reset state after the first reset edge.
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_vld", {31'd0, ov[0]}, 32'd0);
    check("rst_dat", {16'd0, od0}, 32'd0);
    check("rst_ovf", {31'd0, of[0]}, 32'd0);
    check("rst_rdy", {31'd0, ir[0]}, 32'd1);
    check("rst_vld1", {31'd0, ov[1]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    // OR with exact latency per instance.
    lat_probe(3'd0, 40'h10_08_04_02_01, 1'b1, {1'b0, 16'h001F}, {1'b0, 16'h001F});

    // Identity padding and ADD overflow at both output widths.
    send(3'd1, 40'hFF_FF_FF_FF_FF, 1'b1, {1'b0, 16'h00FF}, {1'b0, 16'h00FF});
    send(3'd5, 40'h04_05_07_03_09, 1'b1, {1'b0, 16'h0003}, {1'b0, 16'h0003});
    send(3'd7, 40'hFF_01_00_80_7F, 1'b1, {1'b0, 16'hFF80}, {1'b0, 16'h0080});
    send(3'd6, 40'hFF_01_00_80_7F, 1'b1, {1'b0, 16'h007F}, {1'b0, 16'h007F});
    send(3'd3, 40'hFF_FF_FF_FF_FF, 1'b1, {1'b0, 16'h04FB}, {1'b1, 16'h00FB});
    send(3'd4, 40'h33_81_7F_02_10, 1'b1, {1'b0, 16'h0081}, {1'b0, 16'h0081});
    send(3'd2, 40'hF0_0F_AA_55_01, 1'b1, {1'b0, 16'h0001}, {1'b0, 16'h0001});
    drain();

    // 20 random beats with a 7-cycle downstream stall in the middle.
    n = 0; c = 0;
    while (n < 20 && c < 200) begin
      send_rand();
      out_ready = !(c >= 6 && c < 13);
      #1;
      if (!out_ready) check("stall_rdy", {31'd0, ir[0]}, 32'd0);
      if (ir[0]) n++;
      c++;
    end
    check("stream_cnt", n, 20);
    drain();

    // Throughput: 512 back-to-back beats, all results within the 3-cycle fill.
    t0 = takes[0]; acc = 0;
    for (int i = 0; i < 512; i++) begin
      send_rand();
      #1;
      if (ir[0]) acc++;
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("tput_acc", acc, 512);
    check("tput_out", takes[0] - t0, 512);
    drain();

    // Reset with three beats held in flight.
    out_ready = 1'b0;
    send_rand(); send_rand(); send_rand();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) check($sformatf("mid_rst_vld%0d", i), {31'd0, ov[i]}, 32'd0);
    check("mid_rst_rdy", {31'd0, ir[0]}, 32'd1);
    lat_probe(3'd3, 40'h80_40_20_10_F1, 1'b0, 17'd0, 17'd0);
    drain();
    lat_probe(3'd7, 40'h01_02_03_04_85, 1'b0, 17'd0, 17'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
